clk_rst_sequencer: RTL and testbench

Parametrised clock-enable/divided-clock generator and staged reset sequencer for board top levels driving one or more panel-driver cores. It produces NUM_CH independently divided clocks with runtime-programmable ratios. It also produces per-channel reset outputs that are held after board reset, then released in order, one channel at a time. It replaces the fixed single-divider, single-reset-delay logic in board tops.

---
 rtl/clk_rst_pkg.sv | 21 ++
 rtl/clk_div_channel.sv | 55 +++++
 rtl/clk_rst_sequencer.sv | 148 ++++++++++++++
 tb/tb_clk_rst_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// Shared state type and sizing helpers for the clock/reset sequencer.
package clk_rst_pkg;

   typedef enum logic [1:0] {
      S_HOLD,
      S_DELAY,
      S_STAGGER,
      S_RUN
   } seq_state_t;

   localparam int DIV_CH_MAX = 8;

   // Width able to hold STAGGER-1, never less than one bit.
   function automatic int stagger_w(input int stagger);
      int w;
      w = 1;
      while ((1 << w) < stagger) w++;
      return w;
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divided-clock channel: ratio register, counter, clk_out/clk_en.
// o_fall exists only when CLKSEQ_ALIGN_RELEASE_EN is defined.
module clk_div_channel #(
   parameter int CNT_W       = 16,
   parameter int DIV_DEFAULT = 1000
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             i_ld,
   input  logic [CNT_W-1:0] i_val,
   output logic             o_clk,
   output logic             o_en
`ifdef CLKSEQ_ALIGN_RELEASE_EN
   ,
   output logic             o_fall
`endif
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_ratio;
   logic             r_clk;
   logic             r_en;
   logic             w_tc;

   // A load on the terminal count suppresses the toggle.
   assign w_tc = !i_ld && (r_cnt == r_ratio);

`ifdef CLKSEQ_ALIGN_RELEASE_EN
   assign o_fall = w_tc && r_clk;
`endif

   always_ff @(posedge CLK) begin
      if (rst) begin
         r_cnt   <= '0;
         r_ratio <= CNT_W'(DIV_DEFAULT);
         r_clk   <= 1'b0;
         r_en    <= 1'b0;
      end else begin
         r_en <= w_tc && !r_clk;
         if (i_ld) begin
            r_ratio <= i_val;
            r_cnt   <= '0;
         end else if (w_tc) begin
            r_cnt <= '0;
            r_clk <= ~r_clk;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_clk = r_clk;
   assign o_en  = r_en;

endmodule

// File: rtl/clk_rst_sequencer.sv
// Divided-clock generator with staged per-channel reset release.
// Define CLKSEQ_ALIGN_RELEASE_EN to release each reset on a clk_out fall.
module clk_rst_sequencer
   import clk_rst_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int CH_W        = 1,
   parameter int CNT_W       = 16,
   parameter int DIV_DEFAULT = 1000,
   parameter int DELAY_BIT   = 15,
   parameter int STAGGER     = 256
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              div_wr,
   input  logic [CH_W-1:0]   div_ch,
   input  logic [CNT_W-1:0]  div_val,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] clk_en,
   output logic [NUM_CH-1:0] rst_out,
   output logic              ready
);

   localparam int DW    = DELAY_BIT + 1;
   localparam int SC_W  = stagger_w(STAGGER);
   localparam int IDX_W = $clog2(DIV_CH_MAX);
   localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(STAGGER - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

   seq_state_t        r_state, w_state;
   logic [DW-1:0]     r_dly, w_dly, w_dly_inc;
   logic [SC_W-1:0]   r_sc, w_sc;
   logic [IDX_W-1:0]  r_idx, w_idx;
   logic [NUM_CH-1:0] r_rst_out, w_rel, w_idx_mask;
   logic              r_ready, w_ready;
   logic              w_fall0, w_fall_sel;

`ifdef CLKSEQ_ALIGN_RELEASE_EN
   logic [NUM_CH-1:0] w_fall;
`endif

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_ch
         clk_div_channel #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (DIV_DEFAULT)
         ) u_div (
            .CLK    (CLK),
            .rst    (rst),
            .i_ld   (div_wr && (int'(div_ch) == g)),
            .i_val  (div_val),
            .o_clk  (clk_out[g]),
            .o_en   (clk_en[g])
`ifdef CLKSEQ_ALIGN_RELEASE_EN
            ,
            .o_fall (w_fall[g])
`endif
         );
      end
   endgenerate

   always_comb begin
      w_idx_mask = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_idx == IDX_W'(i)) w_idx_mask[i] = 1'b1;
      end
   end

`ifdef CLKSEQ_ALIGN_RELEASE_EN
   assign w_fall0    = w_fall[0];
   assign w_fall_sel = |(w_fall & w_idx_mask);
`else
   assign w_fall0    = 1'b1;
   assign w_fall_sel = 1'b1;
`endif

   assign w_dly_inc = r_dly + 1'b1;

   always_comb begin
      w_state = r_state;
      w_dly   = r_dly;
      w_sc    = r_sc;
      w_idx   = r_idx;
      w_ready = r_ready;
      w_rel   = '0;
      unique case (r_state)
         S_HOLD: begin
            w_state = S_DELAY;
            w_dly   = '0;
         end
         S_DELAY: begin
            // Saturate once expired so an aligned release can wait.
            if (!r_dly[DELAY_BIT]) w_dly = w_dly_inc;
            if ((w_dly_inc[DELAY_BIT] || r_dly[DELAY_BIT]) && w_fall0) begin
               w_rel[0] = 1'b1;
               w_sc     = '0;
               if (NUM_CH == 1) begin
                  w_state = S_RUN;
                  w_ready = 1'b1;
               end else begin
                  w_state = S_STAGGER;
                  w_idx   = IDX_W'(1);
               end
            end
         end
         S_STAGGER: begin
            if (r_sc != SC_LAST) begin
               w_sc = r_sc + 1'b1;
            end else if (w_fall_sel) begin
               w_rel = w_idx_mask;
               w_sc  = '0;
               if (r_idx == IDX_LAST) begin
                  w_state = S_RUN;
                  w_ready = 1'b1;
               end else begin
                  w_idx = r_idx + 1'b1;
               end
            end
         end
         S_RUN: begin
            w_state = S_RUN;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         r_state   <= S_HOLD;
         r_dly     <= '0;
         r_sc      <= '0;
         r_idx     <= '0;
         r_rst_out <= '1;
         r_ready   <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_dly     <= w_dly;
         r_sc      <= w_sc;
         r_idx     <= w_idx;
         r_rst_out <= r_rst_out & ~w_rel;
         r_ready   <= w_ready;
      end
   end

   assign rst_out = r_rst_out;
   assign ready   = r_ready;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Self-checking bench for clk_rst_sequencer (3 channels, CH_W=2).
// Build with CLKSEQ_ALIGN_RELEASE_EN to exercise aligned release.
module tb_clk_rst_sequencer;

   localparam int NUM_CH    = 3;
   localparam int CH_W      = 2;
   localparam int CNT_W     = 16;
   localparam int DELAY_BIT = 4;
   localparam int STAG      = 5;
`ifdef CLKSEQ_ALIGN_RELEASE_EN
   localparam int DIV_DEF   = 7;
   localparam bit ALIGN     = 1'b1;
`else
   localparam int DIV_DEF   = 3;
   localparam bit ALIGN     = 1'b0;
`endif
   localparam int PER = 2 * (DIV_DEF + 1);

   logic              CLK = 1'b0;
   logic              rst;
   logic              div_wr;
   logic [CH_W-1:0]   div_ch;
   logic [CNT_W-1:0]  div_val;
   logic [NUM_CH-1:0] clk_out, clk_en, rst_out;
   logic              ready;

   always #5 CLK = ~CLK;

   clk_rst_sequencer #(
      .NUM_CH      (NUM_CH),
      .CH_W        (CH_W),
      .CNT_W       (CNT_W),
      .DIV_DEFAULT (DIV_DEF),
      .DELAY_BIT   (DELAY_BIT),
      .STAGGER     (STAG)
   ) u_dut (
      .CLK     (CLK),
      .rst     (rst),
      .div_wr  (div_wr),
      .div_ch  (div_ch),
      .div_val (div_val),
      .clk_out (clk_out),
      .clk_en  (clk_en),
      .rst_out (rst_out),
      .ready   (ready)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference: absolute edge timestamps for toggles and releases.
   int                m_t;
   int                m_ratio [NUM_CH];
   int                m_nt    [NUM_CH];
   logic [NUM_CH-1:0] m_clk, m_en, m_rsto;
   logic              m_rdy;
   int                m_p, m_due;

   logic [NUM_CH-1:0] prev_clk, cur_clk = '0;
   logic [NUM_CH-1:0] prev_rsto, cur_rsto = '1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [NUM_CH-1:0] fall;
      fall = '0;
      if (rst) begin
         m_t    = 0;
         m_p    = 0;
         m_due  = (1 << DELAY_BIT) + 1;
         m_clk  = '0;
         m_en   = '0;
         m_rsto = '1;
         m_rdy  = 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_ratio[i] = DIV_DEF;
            m_nt[i]    = DIV_DEF + 1;
         end
         return;
      end
      m_t++;
      m_en = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (div_wr && int'(div_ch) == i) begin
            m_ratio[i] = int'(div_val);
            m_nt[i]    = m_t + m_ratio[i] + 1;
         end else if (m_t == m_nt[i]) begin
            fall[i]  = m_clk[i];
            m_en[i]  = ~m_clk[i];
            m_clk[i] = ~m_clk[i];
            m_nt[i]  = m_t + m_ratio[i] + 1;
         end
      end
      if (m_p < NUM_CH && m_t >= m_due && (!ALIGN || fall[m_p])) begin
         m_rsto[m_p] = 1'b0;
         m_p++;
         m_due = m_t + STAG;
         if (m_p == NUM_CH) m_rdy = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
      prev_clk  = cur_clk;
      prev_rsto = cur_rsto;
      cur_clk   = clk_out;
      cur_rsto  = rst_out;
      chk("clk_out", 32'(clk_out), 32'(m_clk));
      chk("clk_en",  32'(clk_en),  32'(m_en));
      chk("rst_out", 32'(rst_out), 32'(m_rsto));
      chk("ready",   32'(ready),   32'(m_rdy));
`ifdef CLKSEQ_ALIGN_RELEASE_EN
      for (int i = 0; i < NUM_CH; i++) begin
         if (prev_rsto[i] && !cur_rsto[i])
            chk($sformatf("align_rel%0d", i),
                32'({prev_clk[i], cur_clk[i]}), 32'd2);
      end
`endif
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!ready && n < 400) begin
         step();
         n++;
      end
      chk("ready_wait", 32'(ready), 32'd1);
   endtask

   typedef struct {
      int                e;
      logic [NUM_CH-1:0] clk;
      logic [NUM_CH-1:0] en;
      logic [NUM_CH-1:0] rsto;
      logic              rdy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int e, bit c, bit n, logic [NUM_CH-1:0] r,
                               bit y);
      vec_t v;
      v.e    = e;
      v.clk  = {NUM_CH{c}};
      v.en   = {NUM_CH{n}};
      v.rsto = r;
      v.rdy  = y;
      return v;
   endfunction

   int rises [NUM_CH];
   int n, e;

   initial begin
      tbl.push_back(mk( 1, 0, 0, 3'b111, 0));
      tbl.push_back(mk( 3, 0, 0, 3'b111, 0));
      tbl.push_back(mk( 4, 1, 1, 3'b111, 0));
      tbl.push_back(mk( 5, 1, 0, 3'b111, 0));
      tbl.push_back(mk( 8, 0, 0, 3'b111, 0));
      tbl.push_back(mk(12, 1, 1, 3'b111, 0));
      tbl.push_back(mk(16, 0, 0, 3'b111, 0));
      tbl.push_back(mk(17, 0, 0, 3'b110, 0));
      tbl.push_back(mk(20, 1, 1, 3'b110, 0));
      tbl.push_back(mk(21, 1, 0, 3'b110, 0));
      tbl.push_back(mk(22, 1, 0, 3'b100, 0));
      tbl.push_back(mk(26, 0, 0, 3'b100, 0));
      tbl.push_back(mk(27, 0, 0, 3'b000, 1));
      tbl.push_back(mk(28, 1, 1, 3'b000, 1));
      tbl.push_back(mk(36, 1, 1, 3'b000, 1));

      rst     = 1'b1;
      div_wr  = 1'b0;
      div_ch  = '0;
      div_val = '0;
      repeat (3) step();
      chk("reset.clk_out", 32'(clk_out), 32'd0);
      chk("reset.clk_en",  32'(clk_en),  32'd0);
      chk("reset.rst_out", 32'(rst_out), 32'd7);
      chk("reset.ready",   32'(ready),   32'd0);
      rst = 1'b0;

`ifndef CLKSEQ_ALIGN_RELEASE_EN
      e = 0;
      foreach (tbl[k]) begin
         while (e < tbl[k].e) begin
            step();
            e++;
         end
         chk($sformatf("tbl[e=%0d]", tbl[k].e),
             32'({clk_out, clk_en, rst_out, ready}),
             32'({tbl[k].clk, tbl[k].en, tbl[k].rsto, tbl[k].rdy}));
      end
`endif
      wait_ready();

      // Out-of-range channel select must not disturb any ratio.
      div_wr = 1'b1; div_ch = 2'd3; div_val = '0;
      step();
      div_wr = 1'b0;
      for (int i = 0; i < NUM_CH; i++) rises[i] = 0;
      repeat (64) begin
         step();
         for (int i = 0; i < NUM_CH; i++)
            rises[i] += (cur_clk[i] && !prev_clk[i]) ? 1 : 0;
      end
      for (int i = 0; i < NUM_CH; i++)
         chk($sformatf("oor_rises%0d", i), 32'(rises[i]), 32'(64 / PER));

      // Ratio 0 on channel 1: toggles every CLK, channel 0 unaffected.
      div_wr = 1'b1; div_ch = 2'd1; div_val = '0;
      step();
      div_wr = 1'b0;
      rises[0] = 0;
      for (int c = 0; c < 64; c++) begin
         step();
         rises[0] += (cur_clk[0] && !prev_clk[0]) ? 1 : 0;
         if (c < 6)
            chk("div0_toggle", 32'(cur_clk[1]), 32'(!prev_clk[1]));
      end
      chk("ch0_rises_after_wr", 32'(rises[0]), 32'(64 / PER));

      // Reset pulse while the stagger sequence is in progress.
      rst = 1'b1;
      step();
      rst = 1'b0;
      n = 0;
      while (rst_out !== 3'b110 && n < 200) begin
         step();
         n++;
      end
      chk("reach_stagger", 32'(rst_out), 32'd6);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst.rst_out", 32'(rst_out), 32'd7);
      chk("midrst.ready",   32'(ready),   32'd0);
      chk("midrst.clk_out", 32'(clk_out), 32'd0);
      n = 0;
      while (rst_out[0] && n < 200) begin
         step();
         n++;
      end
`ifdef CLKSEQ_ALIGN_RELEASE_EN
      chk("rel0_after_midrst", 32'(n >= 17 && n < 200), 32'd1);
`else
      chk("rel0_after_midrst", 32'(n), 32'd17);
`endif
      wait_ready();

      // Randomised writes and occasional resets against the model.
      repeat (3000) begin
         rst     = ($urandom_range(0, 299) == 0);
         div_wr  = ($urandom_range(0, 7) == 0);
         div_ch  = CH_W'($urandom_range(0, 3));
         div_val = CNT_W'($urandom_range(0, 12));
         step();
      end
      rst    = 1'b0;
      div_wr = 1'b0;
      wait_ready();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
